key_debounce: RTL

KEY_DEBOUNCE -- requirements
Module: key_debounce

---
 rtl/key_debounce_if.sv | 26 ++
 rtl/key_debounce.sv | 104 ++++++++++
 2 files changed

// File: rtl/key_debounce_if.sv
// rtl/key_debounce_if.sv - key debouncer signal bundle: raw keys in, debounced level and event pulses out
interface key_debounce_if #(
  parameter int unsigned N_KEYS = 4
);
  logic [N_KEYS-1:0] key_in;
  logic [N_KEYS-1:0] key_state;
  logic [N_KEYS-1:0] key_press;
  logic [N_KEYS-1:0] key_release;
  logic [N_KEYS-1:0] key_long;

  modport master (
    output key_in,
    input  key_state,
    input  key_press,
    input  key_release,
    input  key_long
  );

  modport slave (
    input  key_in,
    output key_state,
    output key_press,
    output key_release,
    output key_long
  );
endinterface

// File: rtl/key_debounce.sv
// rtl/key_debounce.sv - multi-channel key debouncer with press, release and long-press pulses
module key_debounce #(
  parameter int unsigned N_KEYS     = 4,
  parameter logic [31:0] DEB_CNT    = 32'd1000000,
  parameter logic [31:0] LONG_CNT   = 32'd50000000,
  parameter bit          ACTIVE_LOW = 1'b1
) (
  input  logic          sys_clk,
  input  logic          sys_rst_n,
  key_debounce_if.slave kb
);
  localparam logic [N_KEYS-1:0] RELEASED_LVL = {N_KEYS{ACTIVE_LOW}};
  localparam logic [31:0]       DEB_LAST     = DEB_CNT - 32'd1;
  localparam logic [31:0]       LONG_LAST    = LONG_CNT - 32'd1;

  logic [N_KEYS-1:0] sync1_q;
  logic [N_KEYS-1:0] sync2_q;
  logic [N_KEYS-1:0] raw;

  logic [N_KEYS-1:0] state_q,   state_d;
  logic [N_KEYS-1:0] press_q,   press_d;
  logic [N_KEYS-1:0] release_q, release_d;
  logic [N_KEYS-1:0] long_q,    long_d;

  logic [31:0] deb_cnt_q  [N_KEYS];
  logic [31:0] deb_cnt_d  [N_KEYS];
  logic [31:0] hold_cnt_q [N_KEYS];
  logic [31:0] hold_cnt_d [N_KEYS];

  // Synchronizer idles at the released level so reset never looks like a press.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      sync1_q <= RELEASED_LVL;
      sync2_q <= RELEASED_LVL;
    end else begin
      sync1_q <= kb.key_in;
      sync2_q <= sync1_q;
    end
  end

  assign raw = ACTIVE_LOW ? ~sync2_q : sync2_q;

  always_comb begin
    state_d   = state_q;
    press_d   = '0;
    release_d = '0;
    for (int i = 0; i < int'(N_KEYS); i++) begin
      deb_cnt_d[i] = deb_cnt_q[i];
      if (raw[i] == state_q[i]) begin
        deb_cnt_d[i] = '0;
      end else if (deb_cnt_q[i] == DEB_LAST) begin
        state_d[i]   = raw[i];
        deb_cnt_d[i] = '0;
        press_d[i]   = raw[i];
        release_d[i] = ~raw[i];
      end else begin
        deb_cnt_d[i] = deb_cnt_q[i] + 32'd1;
      end
    end
  end

  // Hold counter parks at LONG_CNT after firing, which blocks auto-repeat.
  always_comb begin
    long_d = '0;
    for (int i = 0; i < int'(N_KEYS); i++) begin
      hold_cnt_d[i] = hold_cnt_q[i];
      if (!state_q[i]) begin
        hold_cnt_d[i] = '0;
      end else if (hold_cnt_q[i] == LONG_LAST) begin
        hold_cnt_d[i] = LONG_CNT;
        long_d[i]     = 1'b1;
      end else if (hold_cnt_q[i] != LONG_CNT) begin
        hold_cnt_d[i] = hold_cnt_q[i] + 32'd1;
      end
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q   <= '0;
      press_q   <= '0;
      release_q <= '0;
      long_q    <= '0;
      for (int i = 0; i < int'(N_KEYS); i++) begin
        deb_cnt_q[i]  <= '0;
        hold_cnt_q[i] <= '0;
      end
    end else begin
      state_q   <= state_d;
      press_q   <= press_d;
      release_q <= release_d;
      long_q    <= long_d;
      for (int i = 0; i < int'(N_KEYS); i++) begin
        deb_cnt_q[i]  <= deb_cnt_d[i];
        hold_cnt_q[i] <= hold_cnt_d[i];
      end
    end
  end

  assign kb.key_state   = state_q;
  assign kb.key_press   = press_q;
  assign kb.key_release = release_q;
  assign kb.key_long    = long_q;
endmodule
